// File: rtl/mem_arb_pkg.sv
// Shared types and limits for the mem_arbiter block: FSM state enum, size limits
// and the byte-strobe width helper.
package mem_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_WAIT = 1'b1
    } arb_state_e;

    localparam int MAX_REQ = 4;
    localparam int MAX_LAT = 4;
    localparam int CNT_W   = $clog2(MAX_LAT);

    function automatic int strb_w(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side bus of mem_arbiter. The slave modport is the arbiter;
// the master modport is the requesters plus the memory macro.
interface mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
);
    localparam int STRB_W = strb_w(DATA_W);

    // Handshake: request i transfers on a rising edge where req_valid[i] and
    // req_ready[i] are both high; until then the requester holds req_* stable but
    // may drop req_valid. Completion is a single-cycle resp_valid[i] pulse with no
    // back-pressure; resp_rdata is meaningful only while a resp_valid bit is high.
    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ-1:0]             req_ready;
    logic [NUM_REQ-1:0]             req_we;
    logic [NUM_REQ-1:0]             req_lock;
    logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0][DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0][STRB_W-1:0] req_wstrb;
    logic [NUM_REQ-1:0]             resp_valid;
    logic [DATA_W-1:0]              resp_rdata;

    logic                           mem_en;
    logic                           mem_we;
    logic [ADDR_W-1:0]              mem_addr;
    logic [DATA_W-1:0]              mem_wdata;
    logic [STRB_W-1:0]              mem_wstrb;
    logic [DATA_W-1:0]              mem_rdata;

    modport slave (
        input  req_valid, req_we, req_lock, req_addr, req_wdata, req_wstrb, mem_rdata,
        output req_ready, resp_valid, resp_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb
    );

    modport master (
        output req_valid, req_we, req_lock, req_addr, req_wdata, req_wstrb, mem_rdata,
        input  req_ready, resp_valid, resp_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb
    );

endinterface

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational round-robin picker: first valid requester scanning upward from
// ptr_i+1, wrapping modulo NUM_REQ. Returns a one-hot grant and its index.
module rr_picker
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    always_comb begin
        logic found;
        found   = 1'b0;
        grant_o = '0;
        idx_o   = '0;
        // Pass one covers the indices above the pointer, pass two wraps to the rest.
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && (i > int'(ptr_i)) && valid_i[i]) begin
                found      = 1'b1;
                grant_o[i] = 1'b1;
                idx_o      = IDX_W'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && (i <= int'(ptr_i)) && valid_i[i]) begin
                found      = 1'b1;
                grant_o[i] = 1'b1;
                idx_o      = IDX_W'(i);
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous memory between NUM_REQ
// requesters, one transaction at a time. Define MEMARB_LOCK_EN to enable locked sequences.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int LAT     = 1
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus,
    output arb_state_e   dbg_state_o
);

    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int STRB_W = strb_w(DATA_W);

    arb_state_e         state_q;
    logic [IDX_W-1:0]   rr_ptr_q;
    logic [IDX_W-1:0]   owner_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               locked_q;

    logic [NUM_REQ-1:0] owner_mask;
    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_any;
    logic               issue;
    logic               respond;

    assign owner_mask = NUM_REQ'(1) << owner_q;
    assign elig       = locked_q ? (bus.req_valid & owner_mask) : bus.req_valid;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .valid_i (elig),
        .ptr_i   (rr_ptr_q),
        .grant_o (grant),
        .idx_o   (grant_idx),
        .any_o   (grant_any)
    );

    // Gating with reset keeps every output low while reset is held, even with requests pending.
    assign issue   = reset && (state_q == ARB_IDLE) && grant_any;
    assign respond = reset && (state_q == ARB_WAIT) && (cnt_q == '0);

    always_comb begin
        bus.req_ready = '0;
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_wstrb = '0;
        if (issue) begin
            bus.req_ready = grant;
            bus.mem_en    = 1'b1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant[i]) begin
                    bus.mem_we    = bus.req_we[i];
                    bus.mem_addr  = bus.req_addr[i];
                    bus.mem_wdata = bus.req_wdata[i];
                    bus.mem_wstrb = bus.req_wstrb[i];
                end
            end
        end
        bus.resp_valid = respond ? owner_mask : '0;
        bus.resp_rdata = respond ? bus.mem_rdata : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ARB_IDLE;
            rr_ptr_q <= IDX_W'(NUM_REQ - 1);
            cnt_q    <= '0;
            owner_q  <= '0;
        end else begin
            unique case (state_q)
                ARB_IDLE: begin
                    if (grant_any) begin
                        owner_q  <= grant_idx;
                        rr_ptr_q <= grant_idx;
                        cnt_q    <= CNT_W'(LAT - 1);
                        state_q  <= ARB_WAIT;
                    end
                end
                ARB_WAIT: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        state_q <= ARB_IDLE;
                    end
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

`ifdef MEMARB_LOCK_EN
    // The lock bit of each issued transaction decides whether the owner keeps exclusivity.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            locked_q <= 1'b0;
        end else if (issue) begin
            locked_q <= |(bus.req_lock & grant);
        end
    end
`else
    logic unused_lock;
    assign locked_q    = 1'b0;
    assign unused_lock = ^bus.req_lock;
`endif

    assign dbg_state_o = state_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-port synchronous memory between up to four requesters, for example the CPU data port, an instruction-memory loader and a debug port. Each requester uses a valid/ready request and a single-cycle response pulse. A two-state FSM issues one transaction at a time. A round-robin pointer keeps any requester from being starved. The block sits between `SingleCycleCPU`'s data-memory interface and the memory macro.

## Interface
Parameters:
- `NUM_REQ`, 2: number of requesters, legal range 2..4
- `ADDR_W`, 32: address width
- `DATA_W`, 32: data width, a multiple of 8
- `LAT`, 1: memory read latency in cycles, legal range 1..4

Ports:
- `clk`  input  1  clock, rising edge
- `reset`  input  1  asynchronous, active-low reset
- `req_valid`  input  [NUM_REQ]  request pending, one bit per requester
- `req_ready`  output  [NUM_REQ]  request accepted this cycle
- `req_we`  input  [NUM_REQ]  write enable, one bit per requester
- `req_lock`  input  [NUM_REQ]  lock request; used only when `MEMARB_LOCK_EN` is defined
- `req_addr`  input  [NUM_REQ][ADDR_W]  address per requester
- `req_wdata`  input  [NUM_REQ][DATA_W]  write data per requester
- `req_wstrb`  input  [NUM_REQ][DATA_W/8]  byte strobes per requester
- `resp_valid`  output  [NUM_REQ]  one-cycle completion pulse per requester
- `resp_rdata`  output  DATA_W  shared read data; meaningful only while some `resp_valid` bit is set
- `mem_en`, `mem_we`  output  1  memory strobe and write enable
- `mem_addr`, `mem_wdata`, `mem_wstrb`  output  as request  memory command
- `mem_rdata`  input  DATA_W  read data, valid `LAT` cycles after `mem_en`

## Operation
- States: IDLE and WAIT. Each transaction takes 1 issue cycle in IDLE followed by `LAT` cycles in WAIT.
- IDLE with no `req_valid`: all outputs low.
- IDLE with any `req_valid`:
  - Winner `g` is the first valid requester scanning from `rr_ptr+1` upward, modulo `NUM_REQ`.
  - Same cycle, combinationally: `req_ready[g]=1`, `mem_en=1`, and the memory command equals requester `g`'s fields.
  - Registered on the edge: `owner<=g`, `rr_ptr<=g`, `cnt<=LAT-1`, state moves to WAIT.
- WAIT, `cnt!=0`: `cnt` decrements; `mem_en` stays 0 and all `req_ready` bits stay 0.
- WAIT, `cnt==0`: `resp_valid[owner]=1` and `resp_rdata=mem_rdata` (combinational passthrough); next state is IDLE.
- Writes: the response is an acknowledge only; `resp_rdata` carries whatever `mem_rdata` presents.
- At most one `req_ready` bit and at most one `resp_valid` bit is high in any cycle.
- Requesters hold `req_*` stable while `req_valid` is high and `req_ready` is low. Dropping `req_valid` before the grant is legal and nothing is issued for it.
- Reset values: state=IDLE, `rr_ptr=NUM_REQ-1` (so requester 0 has first priority), `cnt=0`, `owner=0`, `locked=0`. Every output is 0 while `reset` is low.

## Timing
- Issue at cycle T gives the response at cycle T+LAT. The earliest next issue is T+LAT+1, so peak throughput is one transaction per LAT+1 cycles.
- Response and grant never overlap: a requester that stays valid is not regranted in its own response cycle.
- Reset asserted mid-transaction: the FSM returns to IDLE immediately, with no response pulse and `mem_en` low. The lost transaction is not replayed.
- Worst-case grant wait with k other active requesters, unlocked: k·(LAT+1) cycles.

## Configuration
- `MEMARB_LOCK_EN` defined:
  - If the winner has `req_lock[g]=1` at issue, `locked` is set.
  - While `locked` is set, only `owner` is eligible in IDLE and all other requesters wait.
  - The owner's first transaction issued with `req_lock=0` is granted normally and clears `locked` at its issue edge.
- `MEMARB_LOCK_EN` undefined: `req_lock` is ignored, `locked` is tied to 0, and arbitration is pure round-robin.

## Structure
- `mem_arb_pkg`: state enum (`ARB_IDLE`, `ARB_WAIT`), `MAX_REQ=4`, `MAX_LAT=4`, and the strobe-width function.
- Sub-module `rr_picker`: purely combinational; inputs are the valid mask and `rr_ptr`, outputs are a one-hot grant and its index. It is instantiated once.
- Counter, owner and lock registers live in `mem_arbiter`.

## Test plan
- Single read, LAT=2: requester 0 reads 0x10 with memory holding 0xDEADBEEF → `req_ready[0]` at T, `resp_valid[0]` at T+2 with data 0xDEADBEEF, and no other pulses.
- Contention, NUM_REQ=3, LAT=1, all valid continuously → grants 0,1,2,0,1,2 on every second cycle, with no grant in any response cycle.
- Write with strobe 4'b0010 and wdata 0x0000AB00 to 0x20, then read 0x20 → byte 1 reads back 0xAB and the other bytes are unchanged.
- Requester 1 drops `req_valid` while requester 0 is in WAIT → no grant and no `mem_en` for requester 1 when the FSM returns to IDLE.
- Reset pulsed in WAIT with `cnt=1`, LAT=3 → outputs go 0 immediately, no `resp_valid` appears, and the next grant goes to requester 0.
- With `MEMARB_LOCK_EN`, requester 1 issues three locked transactions while requester 0 stays valid → requester 0 is first granted only after requester 1's unlocked transaction.
